rr_arb_mux: RTL and testbench

- Parametrised successor to the combinational 4:1 select: an N-input, WIDTH-bit arbitrating multiplexer with a registered output and valid/ready handshakes on every channel.
- Sits between multiple pipeline or memory requesters (e.g. I-fetch, D-mem, uncached path) and one shared downstream consumer such as the bus bridge.
- Supports round-robin or fixed-priority arbitration, back-pressure and a flush.

---
 rtl/rr_arb_mux.sv | 125 ++++++++++++
 tb/tb_rr_arb_mux.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-input, WIDTH-bit arbitrating multiplexer with a registered
// output stage and valid/ready handshakes on every channel.
//
// Arbitration is either round-robin or fixed-priority (lowest index wins).
// The mode can change on any cycle and takes effect immediately.
//
// Ports:
//   clk        single clock; all state updates on the rising edge
//   resetn     synchronous, active-low reset
//   in_valid   per-channel request valid                  [NUM]
//   in_data    packed channel data, channel k at [k*WIDTH +: WIDTH]
//   in_ready   per-channel accept, one-hot or zero        [NUM]
//   prio_mode  0 = round-robin, 1 = fixed priority
//   flush      drops the held output beat and blocks any accept this cycle
//   out_valid  output register holds a beat
//   out_data   registered data of the granted channel     [WIDTH]
//   out_sel    index of the channel that supplied out_data [SEL_W]
//   out_ready  downstream accept
module rr_arb_mux #(
  parameter int WIDTH = 32,
  parameter int NUM   = 4,
  parameter int SEL_W = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NUM-1:0]       in_valid,
  input  logic [NUM*WIDTH-1:0] in_data,
  output logic [NUM-1:0]       in_ready,
  input  logic                 prio_mode,
  input  logic                 flush,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_sel,
  input  logic                 out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_sel_q,   out_sel_d;
  logic [SEL_W-1:0] ptr_q,       ptr_d;

  logic [WIDTH-1:0] chan_data [NUM];
  logic             load;
  logic             win_found;
  logic [SEL_W-1:0] win_idx;
  logic             xfer;

  // Unpack the flat data bus into one word per channel.
  for (genvar gi = 0; gi < NUM; gi++) begin : g_unpack
    assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
  end

  // Gating on resetn keeps every in_ready low while reset is held.
  assign load = resetn & ~flush & (~out_valid_q | out_ready);

  // Winner search. Offsets are visited from highest to lowest so the last
  // hit is the one closest to the search start. The wrap is done by
  // comparison rather than by a modulo so that non-power-of-2 NUM never
  // produces an out-of-range index.
  always_comb begin
    logic [SEL_W-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int off = NUM - 1; off >= 0; off--) begin
      if (prio_mode) begin
        cand = SEL_W'(off);
      end else if (int'(ptr_q) >= NUM - off) begin
        cand = ptr_q - SEL_W'(NUM - off);
      end else begin
        cand = ptr_q + SEL_W'(off);
      end
      if (in_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign xfer = load & win_found;

  for (genvar gi = 0; gi < NUM; gi++) begin : g_ready
    assign in_ready[gi] = xfer && (win_idx == SEL_W'(gi));
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (load) begin
      // A drain with no new winner empties the register but leaves the
      // last data/sel visible.
      out_valid_d = win_found;
      if (win_found) begin
        out_data_d = chan_data[win_idx];
        out_sel_d  = win_idx;
        if (!prio_mode) begin
          ptr_d = (win_idx == SEL_W'(NUM - 1)) ? '0 : win_idx + SEL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: self-checking bench for rr_arb_mux (NUM=4, WIDTH=32).
// A behavioural model tracks the output register and the round-robin
// pointer; a compare process checks every DUT output against it on every
// falling edge. Directed scenarios add literal expectations, then a long
// randomized run exercises mode changes, back-pressure, flush and reset.
module tb_rr_arb_mux;

  localparam int WIDTH = 32;
  localparam int NUM   = 4;
  localparam int SEL_W = 2;

  logic                 clk;
  logic                 resetn;
  logic [NUM-1:0]       in_valid;
  logic [NUM*WIDTH-1:0] in_data;
  logic [NUM-1:0]       in_ready;
  logic                 prio_mode;
  logic                 flush;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [SEL_W-1:0]     out_sel;
  logic                 out_ready;

  int n_cmp  = 0;
  int n_fail = 0;

  rr_arb_mux #(.WIDTH(WIDTH), .NUM(NUM), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .prio_mode (prio_mode),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic             m_init  = 1'b0;
  logic             m_valid = 1'b0;
  logic [WIDTH-1:0] m_data  = '0;
  int               m_sel   = 0;
  int               m_ptr   = 0;

  // Index of the granted channel, or -1 when nothing is requesting.
  function automatic int winner(input logic [NUM-1:0] v, input int ptr, input logic prio);
    for (int off = 0; off < NUM; off++) begin
      int idx;
      idx = prio ? off : (ptr + off) % NUM;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [NUM-1:0] exp_ready();
    int w;
    if (!resetn || flush || (m_valid && !out_ready)) return '0;
    w = winner(in_valid, m_ptr, prio_mode);
    if (w < 0) return '0;
    return NUM'(1) << w;
  endfunction

  always @(posedge clk) begin
    if (!resetn) begin
      m_init  <= 1'b1;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sel   <= 0;
      m_ptr   <= 0;
    end else if (m_init) begin
      if (flush) begin
        m_valid <= 1'b0;
      end else if (!m_valid || out_ready) begin
        if (winner(in_valid, m_ptr, prio_mode) >= 0) begin
          m_valid <= 1'b1;
          m_data  <= in_data[winner(in_valid, m_ptr, prio_mode)*WIDTH +: WIDTH];
          m_sel   <= winner(in_valid, m_ptr, prio_mode);
          if (!prio_mode) m_ptr <= (winner(in_valid, m_ptr, prio_mode) + 1) % NUM;
        end else begin
          m_valid <= 1'b0;
        end
      end
    end
  end

  // Compare process: every falling edge once the model is initialised.
  always @(negedge clk) begin
    if (m_init) begin
      chk("mdl_in_ready", 64'(in_ready), 64'(exp_ready()));
      chk("mdl_out_valid", 64'(out_valid), 64'(m_valid));
      chk("mdl_out_data", 64'(out_data), 64'(m_data));
      chk("mdl_out_sel", 64'(out_sel), 64'(m_sel));
    end
  end

  // ---------------- stimulus ----------------
  task automatic at_neg();
    @(negedge clk);
    #2;
  endtask

  task automatic set_default_data();
    for (int k = 0; k < NUM; k++) in_data[k*WIDTH +: WIDTH] = 32'h1000_0000 + 32'(k);
  endtask

  initial begin
    resetn    = 1'b0;
    in_valid  = 4'b1111;
    prio_mode = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    set_default_data();

    // Reset held for two edges with every channel requesting.
    at_neg();
    chk("rst_in_ready_1", 64'(in_ready), 64'h0);
    at_neg();
    chk("rst_in_ready_2", 64'(in_ready), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data", 64'(out_data), 64'h0);
    chk("rst_out_sel", 64'(out_sel), 64'h0);
    resetn = 1'b1;
    #1;
    chk("rr_first_ready", 64'(in_ready), 64'h1);

    // Round-robin fairness: 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      at_neg();
      chk("rr_valid", 64'(out_valid), 64'h1);
      chk("rr_sel", 64'(out_sel), 64'(i % NUM));
      chk("rr_data", 64'(out_data), 64'h1000_0000 + 64'(i % NUM));
    end

    // Back-pressure: ch2 accepted with DEADBEEF, then stalled three cycles.
    in_valid = 4'b0100;
    in_data[2*WIDTH +: WIDTH] = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("bp_data", 64'(out_data), 64'hDEAD_BEEF);
      chk("bp_sel", 64'(out_sel), 64'h2);
      chk("bp_in_ready", 64'(in_ready), 64'h0);
    end
    out_ready = 1'b1;
    set_default_data();
    #1;
    chk("bp_next_ready", 64'(in_ready), 64'h8);
    at_neg();
    chk("bp_next_sel", 64'(out_sel), 64'h3);
    chk("bp_next_data", 64'(out_data), 64'h1000_0003);

    // Sparse and wrap: steer ptr to 3, then request 0101.
    in_valid = 4'b0100;
    at_neg();
    chk("sp_setup_sel", 64'(out_sel), 64'h2);
    in_valid = 4'b0101;
    #1;
    chk("sp_wrap_ready", 64'(in_ready), 64'h1);
    at_neg();
    chk("sp_wrap_sel", 64'(out_sel), 64'h0);
    chk("sp_ptr1_ready", 64'(in_ready), 64'h4);
    at_neg();
    chk("sp_ch2_sel", 64'(out_sel), 64'h2);
    chk("sp_ptr3_ready", 64'(in_ready), 64'h1);

    // Fixed priority with 1010: ch1 wins every cycle, ptr stays at 3.
    prio_mode = 1'b1;
    in_valid  = 4'b1010;
    #1;
    chk("fp_ready", 64'(in_ready), 64'h2);
    for (int i = 0; i < 4; i++) begin
      at_neg();
      chk("fp_sel", 64'(out_sel), 64'h1);
      chk("fp_hold_ready", 64'(in_ready), 64'h2);
    end
    prio_mode = 1'b0;
    #1;
    chk("fp_to_rr_ready", 64'(in_ready), 64'h8);
    at_neg();
    chk("fp_to_rr_sel", 64'(out_sel), 64'h3);

    // Flush while holding a stalled beat; ptr (now 0) must be untouched.
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    flush     = 1'b1;
    #1;
    chk("fl_in_ready", 64'(in_ready), 64'h0);
    at_neg();
    chk("fl_out_valid", 64'(out_valid), 64'h0);
    flush     = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("fl_ptr_ready", 64'(in_ready), 64'h1);
    at_neg();
    chk("fl_next_sel", 64'(out_sel), 64'h0);
    chk("fl_next_valid", 64'(out_valid), 64'h1);

    // Randomized run; inputs change just after each rising edge.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk);
      #1;
      resetn    = ($urandom_range(99) != 0);
      in_valid  = NUM'($urandom_range(15));
      for (int k = 0; k < NUM; k++) in_data[k*WIDTH +: WIDTH] = $urandom;
      out_ready = ($urandom_range(9) < 7);
      prio_mode = ($urandom_range(9) == 0);
      flush     = ($urandom_range(19) == 0);
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    flush  = 1'b0;
    at_neg();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
